bpu_update_queue: RTL and testbench
===================================

BPU_UPDATE_QUEUE -- requirements
Module: bpu_update_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of in-flight prediction entries; power of two, minimum 2.
REQ-002 Ports: clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 Ports: rst  in  1  reset, synchronous, active-low.
REQ-004 Ports: pred_valid_i  in  1  fetch stage enqueues one predicted branch.
REQ-005 Ports: pred_pc_i  in  32  branch PC.
REQ-006 Ports: pred_taken_i  in  1  TAGE taken prediction.
REQ-007 Ports: pred_target_i  in  32  BTB target.
REQ-008 Ports: enq_ready_o  out  1  queue not full.
REQ-009 Ports: resolve_valid_i  in  1  execute resolves the oldest entry.
REQ-010 Ports: resolve_taken_i  in  1  actual direction.
REQ-011 Ports: resolve_target_i  in  32  actual target.
REQ-012 Ports: resolve_ready_o  out  1  queue not empty.
REQ-013 Ports: flush_i  in  1  external pipeline flush.
REQ-014 Ports: update_valid_o, update_taken_o, update_pc_o[32], update_target_o[32]  out  predictor training pulse; feeds the predictor's branch update inputs.
REQ-015 Ports: redirect_valid_o  out  1  and redirect_pc_o  out  32  fetch redirect on mispredict.

Function
REQ-016 Storage is a circular buffer of DEPTH entries {pc, taken, target} with head and tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0, plus a count of log2(DEPTH)+1 bits.
REQ-017 enq_ready_o = (count != DEPTH); resolve_ready_o = (count != 0); both combinational from registered count.
REQ-018 Enqueue fires when pred_valid_i && enq_ready_o and no flush condition (REQ-022) is active; entry is written at tail and tail advances.
REQ-019 Resolve fires when resolve_valid_i && resolve_ready_o; the head entry is popped; a resolve_valid_i on an empty queue is ignored with no output.
REQ-020 Resolve at cycle N drives update_valid_o=1 at N+1 for exactly one cycle, with update_pc_o=head pc, update_taken_o=resolve_taken_i, update_target_o=resolve_target_i.
REQ-021 Mispredict occurs when resolve_taken_i != head taken, or when both are taken and resolve_target_i != head target.
REQ-022 Mispredict at cycle N drives redirect_valid_o=1 at N+1 for exactly one cycle, with redirect_pc_o = resolve_taken_i ? resolve_target_i : head pc + 4 (32-bit wrap); count, head and tail are cleared at N+1 and any same-cycle enqueue is dropped.
REQ-023 Simultaneous enqueue and non-mispredicting resolve leave count unchanged; there is no enqueue-into-freed-slot bypass when full.
REQ-024 flush_i at cycle N clears count, head and tail at N+1 and drops any same-cycle enqueue; a same-cycle resolve still produces update_valid_o, but redirect_valid_o is suppressed.
REQ-025 update_* and redirect_* outputs are registered; payload outputs hold their last value when the valid signal is low.

Reset
REQ-026 When rst=0 at posedge clk: count, head, tail=0; update_valid_o=0, redirect_valid_o=0; update_pc_o, update_target_o, redirect_pc_o=0; update_taken_o=0.
REQ-027 Reset asserted mid-operation discards all entries; after reset, enq_ready_o=1 and resolve_ready_o=0 regardless of prior state.
REQ-028 Entry storage is not reset; only valid state (count and pointers) is reset.

Configuration
REQ-029 Macro BPU_PERF_COUNTER_EN, when defined, adds outputs perf_resolve_cnt_o[32] and perf_mispredict_cnt_o[32]; these increment on each fired resolve and each mispredict respectively, wrap at 2^32, and reset to 0.
REQ-030 Without BPU_PERF_COUNTER_EN, these ports and their counters do not exist, and all other behaviour is identical.

Verification
REQ-031 After reset, enqueue pc=0x1C000000, taken=1, target=0x1C000040; resolve taken=1, target=0x1C000040 -> next cycle update_valid_o=1, update_pc_o=0x1C000000, redirect_valid_o=0.
REQ-032 Enqueue 8 entries with DEPTH=8 -> enq_ready_o=0; a 9th pred_valid_i is dropped; 8 resolves drain the queue in FIFO order, and tail wraps correctly on re-enqueue.
REQ-033 Entry pc=0x1C000100 predicted taken, resolved not-taken -> redirect_valid_o=1 with redirect_pc_o=0x1C000104; count=0 next cycle, and a same-cycle enqueue is lost.
REQ-034 Target mismatch: predicted 0x1C000200, resolved taken to 0x1C000300 -> redirect_pc_o=0x1C000300, and update_target_o=0x1C000300.
REQ-035 flush_i in the same cycle as a correct resolve and an enqueue -> update_valid_o=1, no redirect, count=0, resolve_ready_o=0.
REQ-036 rst=0 asserted with 5 entries queued -> all outputs reach reset values the next cycle; with BPU_PERF_COUNTER_EN, both counters read 0.

Source files
------------

// File: rtl/bpu_update_queue.sv
// bpu_update_queue: in-flight branch predictions, resolved in order, train + redirect.
// Optional BPU_PERF_COUNTER_EN adds resolve/mispredict counters.
module bpu_update_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid_i,
  input  logic [31:0] pred_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  output logic        enq_ready_o,
  input  logic        resolve_valid_i,
  input  logic        resolve_taken_i,
  input  logic [31:0] resolve_target_i,
  output logic        resolve_ready_o,
  input  logic        flush_i,
  output logic        update_valid_o,
  output logic        update_taken_o,
  output logic [31:0] update_pc_o,
  output logic [31:0] update_target_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
`ifdef BPU_PERF_COUNTER_EN
  ,
  output logic [31:0] perf_resolve_cnt_o,
  output logic [31:0] perf_mispredict_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [31:0]   pc_q     [DEPTH];
  logic          taken_q  [DEPTH];
  logic [31:0]   target_q [DEPTH];

  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_d;

  logic [31:0]   hd_pc, hd_target;
  logic          hd_taken;
  logic          res_fire, enq_fire;
  logic          mispred, clr;

  assign enq_ready_o     = (count_q != FULL);
  assign resolve_ready_o = (count_q != '0);

  assign hd_pc     = pc_q[head_q];
  assign hd_taken  = taken_q[head_q];
  assign hd_target = target_q[head_q];

  // Fire conditions; any clear (flush or mispredict) drops the enqueue
  always_comb begin
    res_fire = resolve_valid_i && resolve_ready_o;
    mispred  = 1'b0;
    if (res_fire) begin
      mispred = (resolve_taken_i != hd_taken) ||
                (resolve_taken_i && hd_taken &&
                 (resolve_target_i != hd_target));
    end
    clr      = flush_i || mispred;
    enq_fire = pred_valid_i && enq_ready_o && !clr;
    count_d  = count_q;
    if (clr) begin
      count_d = '0;
    end else begin
      unique case ({enq_fire, res_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Entry payload storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_q[tail_q]     <= pred_pc_i;
      taken_q[tail_q]  <= pred_taken_i;
      target_q[tail_q] <= pred_target_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (res_fire) head_q <= head_q + 1'b1;
      if (enq_fire) tail_q <= tail_q + 1'b1;
    end
  end

  // Registered training pulse; payload holds while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      update_valid_o  <= 1'b0;
      update_taken_o  <= 1'b0;
      update_pc_o     <= '0;
      update_target_o <= '0;
    end else begin
      update_valid_o <= res_fire;
      if (res_fire) begin
        update_taken_o  <= resolve_taken_i;
        update_pc_o     <= hd_pc;
        update_target_o <= resolve_target_i;
      end
    end
  end

  // Registered fetch redirect; an external flush already redirects fetch
  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      redirect_valid_o <= mispred && !flush_i;
      if (mispred && !flush_i) begin
        redirect_pc_o <= resolve_taken_i ? resolve_target_i
                                         : hd_pc + 32'd4;
      end
    end
  end

`ifdef BPU_PERF_COUNTER_EN
  // Free-running event counters, wrap at 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_resolve_cnt_o    <= '0;
      perf_mispredict_cnt_o <= '0;
    end else begin
      if (res_fire) perf_resolve_cnt_o    <= perf_resolve_cnt_o + 32'd1;
      if (mispred)  perf_mispredict_cnt_o <= perf_mispredict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_update_queue.sv
// tb_bpu_update_queue: directed + random stimulus vs a queue-based model.
// Checks readiness, training pulses, redirects, flush and reset.
module tb_bpu_update_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid_i, pred_taken_i;
  logic [31:0] pred_pc_i, pred_target_i;
  logic        enq_ready_o;
  logic        resolve_valid_i, resolve_taken_i;
  logic [31:0] resolve_target_i;
  logic        resolve_ready_o;
  logic        flush_i;
  logic        update_valid_o, update_taken_o;
  logic [31:0] update_pc_o, update_target_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
`ifdef BPU_PERF_COUNTER_EN
  logic [31:0] perf_resolve_cnt_o, perf_mispredict_cnt_o;
`endif

  bpu_update_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_valid_i     (pred_valid_i),
    .pred_pc_i        (pred_pc_i),
    .pred_taken_i     (pred_taken_i),
    .pred_target_i    (pred_target_i),
    .enq_ready_o      (enq_ready_o),
    .resolve_valid_i  (resolve_valid_i),
    .resolve_taken_i  (resolve_taken_i),
    .resolve_target_i (resolve_target_i),
    .resolve_ready_o  (resolve_ready_o),
    .flush_i          (flush_i),
    .update_valid_o   (update_valid_o),
    .update_taken_o   (update_taken_o),
    .update_pc_o      (update_pc_o),
    .update_target_o  (update_target_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
`ifdef BPU_PERF_COUNTER_EN
    ,
    .perf_resolve_cnt_o    (perf_resolve_cnt_o),
    .perf_mispredict_cnt_o (perf_mispredict_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t        q[$];
  logic        e_uv, e_ut, e_rv;
  logic [31:0] e_upc, e_utg, e_rpc;
`ifdef BPU_PERF_COUNTER_EN
  logic [31:0] e_nres, e_nmis;
`endif
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_outs();
    chk("update_valid", {31'b0, update_valid_o}, {31'b0, e_uv});
    chk("update_taken", {31'b0, update_taken_o}, {31'b0, e_ut});
    chk("update_pc", update_pc_o, e_upc);
    chk("update_target", update_target_o, e_utg);
    chk("redirect_valid", {31'b0, redirect_valid_o}, {31'b0, e_rv});
    chk("redirect_pc", redirect_pc_o, e_rpc);
`ifdef BPU_PERF_COUNTER_EN
    chk("perf_resolve", perf_resolve_cnt_o, e_nres);
    chk("perf_mispredict", perf_mispredict_cnt_o, e_nmis);
`endif
  endtask

  // One clock with the given inputs; model updated from the rules
  task automatic cyc(input logic pv, input logic [31:0] pc,
                     input logic pt, input logic [31:0] ptg,
                     input logic rv, input logic rt,
                     input logic [31:0] rtg, input logic fl);
    ent_t h;
    logic res, mis, clr, enq;
    chk("enq_ready", {31'b0, enq_ready_o}, {31'b0, q.size() != DEPTH});
    chk("resolve_ready", {31'b0, resolve_ready_o}, {31'b0, q.size() != 0});
    pred_valid_i = pv; pred_pc_i = pc;
    pred_taken_i = pt; pred_target_i = ptg;
    resolve_valid_i = rv; resolve_taken_i = rt;
    resolve_target_i = rtg; flush_i = fl;
    res = rv && (q.size() > 0);
    mis = 1'b0;
    h = '0;
    if (res) begin
      h = q[0];
      mis = (rt != h.taken) || (rt && h.taken && rtg != h.target);
    end
    clr = fl || mis;
    enq = pv && (q.size() != DEPTH) && !clr;
    e_uv = res;
    if (res) begin
      e_ut = rt; e_upc = h.pc; e_utg = rtg;
    end
    e_rv = mis && !fl;
    if (e_rv) e_rpc = rt ? rtg : h.pc + 32'd4;
`ifdef BPU_PERF_COUNTER_EN
    if (res) e_nres++;
    if (mis) e_nmis++;
`endif
    if (clr) q.delete();
    else begin
      if (res) void'(q.pop_front());
      if (enq) q.push_back('{pc, pt, ptg});
    end
    @(posedge clk); #1;
    chk_outs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pred_valid_i = 1'b1; pred_pc_i = $urandom; pred_taken_i = 1'b1;
    pred_target_i = $urandom; resolve_valid_i = 1'b1;
    resolve_taken_i = 1'b0; resolve_target_i = $urandom; flush_i = 1'b0;
    q.delete();
    e_uv = 0; e_ut = 0; e_upc = 0; e_utg = 0; e_rv = 0; e_rpc = 0;
`ifdef BPU_PERF_COUNTER_EN
    e_nres = 0; e_nmis = 0;
`endif
    @(posedge clk); #1;
    chk_outs();
    rst = 1'b1;
    chk("rst_enq_ready", {31'b0, enq_ready_o}, 32'd1);
    chk("rst_resolve_ready", {31'b0, resolve_ready_o}, 32'd0);
  endtask

  initial begin
    logic        pv, pt, rv, rt, fl;
    logic [31:0] pc, ptg, rtg;

    do_reset();

    // Correct resolve trains without redirect
    cyc(1, 32'h1C00_0000, 1, 32'h1C00_0040, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h1C00_0040, 0);
    chk("basic_update_pc", update_pc_o, 32'h1C00_0000);
    chk("basic_update_valid", {31'b0, update_valid_o}, 32'd1);
    chk("basic_no_redirect", {31'b0, redirect_valid_o}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("update_one_cycle", {31'b0, update_valid_o}, 32'd0);

    // Fill, overflow drop, drain FIFO, wrap
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 32'h2000_0000 + 32'(i * 16), 0, 0, 0, 0, 0, 0);
    chk("full_enq_ready", {31'b0, enq_ready_o}, 32'd0);
    cyc(1, 32'hDEAD_0000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 32'h55, 0);
      chk("fifo_order", update_pc_o, 32'h2000_0000 + 32'(i * 16));
    end
    chk("drained", {31'b0, resolve_ready_o}, 32'd0);
    for (int i = 0; i < 5; i++)
      cyc(1, 32'h3000_0000 + 32'(i * 4), 1, 32'h3100_0000, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(1, 32'h3200_0000 + 32'(i * 4), 1, 32'h3300_0000, 1, 1,
          32'h3100_0000, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1, 1, 32'h3300_0000, 0);
      chk("wrap_order", update_pc_o, 32'h3200_0000 + 32'(i * 4));
    end

    // Direction mispredict drops the same-cycle enqueue
    cyc(1, 32'h1C00_0100, 1, 32'h1C00_0180, 0, 0, 0, 0);
    cyc(1, 32'h1C00_0110, 0, 0, 1, 0, 32'h0, 0);
    chk("dir_redirect_valid", {31'b0, redirect_valid_o}, 32'd1);
    chk("dir_redirect_pc", redirect_pc_o, 32'h1C00_0104);
    chk("dir_cleared", {31'b0, resolve_ready_o}, 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("empty_resolve_ignored", {31'b0, update_valid_o}, 32'd0);

    // Target mispredict
    cyc(1, 32'h1C00_0200, 1, 32'h1C00_0200, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 32'h1C00_0300, 0);
    chk("tgt_redirect_pc", redirect_pc_o, 32'h1C00_0300);
    chk("tgt_update_target", update_target_o, 32'h1C00_0300);

    // Flush with correct resolve and enqueue
    cyc(1, 32'h4000_0000, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h4000_0004, 0, 0, 1, 0, 0, 1);
    chk("flush_update", {31'b0, update_valid_o}, 32'd1);
    chk("flush_no_redirect", {31'b0, redirect_valid_o}, 32'd0);
    chk("flush_empty", {31'b0, resolve_ready_o}, 32'd0);

    // Flush suppresses a mispredict redirect
    cyc(1, 32'h4100_0000, 1, 32'h4200_0000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 1);

    // Reset with five queued entries
    for (int i = 0; i < 5; i++)
      cyc(1, 32'h5000_0000 + 32'(i), 1, 32'h5100_0000, 0, 0, 0, 0);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      pv  = ($urandom_range(0, 3) != 0);
      pc  = $urandom & 32'hFFFF_FFFC;
      pt  = 1'($urandom);
      ptg = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 : $urandom;
      rv  = ($urandom_range(0, 1) == 0);
      rt  = 1'($urandom);
      rtg = $urandom;
      if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
        rt = q[0].taken;
        if (q[0].taken) rtg = q[0].target;
      end
      fl  = ($urandom_range(0, 39) == 0);
      cyc(pv, pc, pt, ptg, rv, rt, rtg, fl);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
